sd_quad_nco_modulator: RTL and testbench

//  Quadrature NCO with 1-bit sigma-delta outputs: phase accumulator -> quarter-wave sine LUT
//  -> amplitude scale -> per-channel sigma-delta modulator.

---
 rtl/sd_quad_nco_modulator_if.sv | 24 ++
 rtl/sd_quad_nco_modulator.sv | 198 +++++++++++++++++++
 tb/tb_sd_quad_nco_modulator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_quad_nco_modulator_if.sv
// Configuration handshake, sample enable and bitstream outputs of the quadrature sigma-delta NCO.
interface sd_quad_nco_modulator_if #(
  parameter int WIDTH       = 16,
  parameter int PHASE_WIDTH = 24
);
  logic                   en;
  logic                   cfgValid;
  logic                   cfgReady;
  logic [PHASE_WIDTH-1:0] cfgFreq;
  logic [WIDTH-1:0]       cfgAmp;
  logic                   outSin;
  logic                   outCos;
  logic                   phaseWrap;

  modport master (
    output en, cfgValid, cfgFreq, cfgAmp,
    input  cfgReady, outSin, outCos, phaseWrap
  );

  modport slave (
    input  en, cfgValid, cfgFreq, cfgAmp,
    output cfgReady, outSin, outCos, phaseWrap
  );
endinterface

// File: rtl/sd_quad_nco_modulator.sv
// Quadrature NCO -> quarter-wave sine ROM -> amplitude scale -> 1-bit sigma-delta per channel.
// Define SD_QUAD_MOD_ORDER2_EN for 2nd-order modulators; the default build uses 1st-order.
module sd_quad_nco_modulator #(
  parameter int WIDTH       = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sd_quad_nco_modulator_if.slave bus
);

  localparam int  DEPTH   = 1 << LUT_BITS;
  localparam int  TOP_W   = LUT_BITS + 2;
  localparam int  AMP_MAX = (1 << (WIDTH - 1)) - 1;
  localparam real PI      = 3.14159265358979323846;
`ifdef SD_QUAD_MOD_ORDER2_EN
  localparam int  MOD_W   = WIDTH + 4;
`else
  localparam int  MOD_W   = WIDTH + 2;
`endif
  localparam logic signed [MOD_W-1:0] FS = MOD_W'(1 << (WIDTH - 1));

  // Quarter-wave table sampled at bin centres, evaluated at elaboration time.
  function automatic logic [DEPTH*WIDTH-1:0] build_rom();
    logic [DEPTH*WIDTH-1:0] rom;
    real ang, term, s;
    rom = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ang  = 2.0 * PI * (real'(i) + 0.5) / real'(4 * DEPTH);
      term = ang;
      s    = ang;
      for (int k = 1; k < 12; k++) begin
        term = -term * ang * ang / real'((2 * k) * (2 * k + 1));
        s    = s + term;
      end
      rom[i*WIDTH +: WIDTH] = WIDTH'($rtoi(s * real'(AMP_MAX) + 0.5));
    end
    return rom;
  endfunction

  localparam logic [DEPTH*WIDTH-1:0] ROM = build_rom();

  function automatic logic signed [WIDTH-1:0] quad_sine(input logic [TOP_W-1:0] top);
    logic [LUT_BITS-1:0]     idx;
    logic signed [WIDTH-1:0] mag;
    idx = top[LUT_BITS-1:0];
    if (top[TOP_W-2]) idx = ~idx;
    mag = ROM[int'(idx)*WIDTH +: WIDTH];
    return top[TOP_W-1] ? -mag : mag;
  endfunction

  // Product is floored by the arithmetic shift; |result| < 2^(WIDTH-1) for any amplitude.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0]        amp);
    logic signed [2*WIDTH:0] prod;
    prod = (2*WIDTH+1)'(s) * (2*WIDTH+1)'($signed({1'b0, amp}));
    return WIDTH'(prod >>> WIDTH);
  endfunction

  function automatic logic signed [MOD_W-1:0] feedback(input logic y);
    return y ? FS : -FS;
  endfunction

  typedef enum logic {SH_EMPTY, SH_FULL} sh_state_t;

  sh_state_t               r_shState, w_shNext;
  logic                    w_load, w_copy, w_cfgReady;
  logic [PHASE_WIDTH-1:0]  r_phase, r_freqAct, r_freqSh, w_phaseSum;
  logic [WIDTH-1:0]        r_ampAct, r_ampSh;
  logic                    w_carry;
  logic [TOP_W-1:0]        w_sinTop, w_cosTop;

  logic signed [WIDTH-1:0] r_lut_p0 [2];
  logic signed [WIDTH-1:0] r_x_p1   [2];
  logic                    r_out_p2 [2];
  logic                    w_y      [2];
`ifdef SD_QUAD_MOD_ORDER2_EN
  logic signed [MOD_W-1:0] r_i1_p2  [2];
  logic signed [MOD_W-1:0] r_i2_p2  [2];
`else
  logic signed [MOD_W-1:0] r_e_p2   [2];
`endif

  assign {w_carry, w_phaseSum} = {1'b0, r_phase} + {1'b0, r_freqAct};

  always_ff @(posedge clk) begin
    if (rst) r_shState <= SH_EMPTY;
    else     r_shState <= w_shNext;
  end

  // A stopped accumulator never wraps, so a zero frequency also releases the shadow.
  always_comb begin
    w_shNext   = r_shState;
    w_load     = 1'b0;
    w_copy     = 1'b0;
    w_cfgReady = 1'b0;
    case (r_shState)
      SH_EMPTY: begin
        w_cfgReady = 1'b1;
        if (bus.cfgValid) begin
          w_load   = 1'b1;
          w_shNext = SH_FULL;
        end
      end
      SH_FULL: begin
        if (bus.en && (w_carry || (r_freqAct == '0))) begin
          w_copy   = 1'b1;
          w_shNext = SH_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_freqSh  <= '0;
      r_ampSh   <= '0;
      r_freqAct <= '0;
      r_ampAct  <= '0;
      r_phase   <= '0;
    end else begin
      if (w_load) begin
        r_freqSh <= bus.cfgFreq;
        r_ampSh  <= bus.cfgAmp;
      end
      if (w_copy) begin
        r_freqAct <= r_freqSh;
        r_ampAct  <= r_ampSh;
      end
      if (bus.en) r_phase <= w_phaseSum;
    end
  end

  assign bus.cfgReady  = w_cfgReady;
  assign bus.phaseWrap = bus.en & w_carry & ~rst;

  // The quarter-turn cosine offset only touches the bits that address the ROM.
  assign w_sinTop = r_phase[PHASE_WIDTH-1 -: TOP_W];
  assign w_cosTop = w_sinTop + TOP_W'(DEPTH);

  // Stage p0: ROM lookup; stage p1: amplitude scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_lut_p0[c] <= '0;
        r_x_p1[c]   <= '0;
      end
    end else if (bus.en) begin
      r_lut_p0[0] <= quad_sine(w_sinTop);
      r_lut_p0[1] <= quad_sine(w_cosTop);
      for (int c = 0; c < 2; c++) r_x_p1[c] <= scale(r_lut_p0[c], r_ampAct);
    end
  end

  // Stage p2: sigma-delta modulator, one per channel.
`ifdef SD_QUAD_MOD_ORDER2_EN
  assign w_y[0] = ~r_i2_p2[0][MOD_W-1];
  assign w_y[1] = ~r_i2_p2[1][MOD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_i1_p2[c]  <= '0;
        r_i2_p2[c]  <= '0;
        r_out_p2[c] <= 1'b0;
      end
    end else if (bus.en) begin
      for (int c = 0; c < 2; c++) begin
        r_i1_p2[c]  <= r_i1_p2[c] + MOD_W'(r_x_p1[c]) - feedback(w_y[c]);
        r_i2_p2[c]  <= r_i2_p2[c] + r_i1_p2[c] - feedback(w_y[c]);
        r_out_p2[c] <= w_y[c];
      end
    end
  end
`else
  assign w_y[0] = ~r_e_p2[0][MOD_W-1];
  assign w_y[1] = ~r_e_p2[1][MOD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_e_p2[c]   <= '0;
        r_out_p2[c] <= 1'b0;
      end
    end else if (bus.en) begin
      for (int c = 0; c < 2; c++) begin
        r_e_p2[c]   <= r_e_p2[c] + MOD_W'(r_x_p1[c]) - feedback(w_y[c]);
        r_out_p2[c] <= w_y[c];
      end
    end
  end
`endif

  assign bus.outSin = r_out_p2[0];
  assign bus.outCos = r_out_p2[1];

endmodule

// File: tb/tb_sd_quad_nco_modulator.sv
// Scoreboard bench for sd_quad_nco_modulator: random and directed stimulus against a behavioural tone model.
module tb_sd_quad_nco_modulator;
  localparam int     WIDTH    = 16;
  localparam int     PW       = 24;
  localparam int     LUT_BITS = 8;
  localparam real    PI       = 3.14159265358979323846;
  localparam longint PMOD     = longint'(1) << PW;
  localparam longint FS       = longint'(1) << (WIDTH - 1);
  localparam longint AMAX     = FS - 1;
`ifdef SD_QUAD_MOD_ORDER2_EN
  localparam int     MOD_W    = WIDTH + 4;
`else
  localparam int     MOD_W    = WIDTH + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_quad_nco_modulator_if #(.WIDTH(WIDTH), .PHASE_WIDTH(PW)) bus();

  sd_quad_nco_modulator #(.WIDTH(WIDTH), .PHASE_WIDTH(PW), .LUT_BITS(LUT_BITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef logic [3:0] obs_t;  // {cfgReady, outSin, outCos, phaseWrap}
  obs_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;
  int cnt_sin, cnt_cos, cnt_wrap, en_cnt, last_wrap_at, last_iv;

  // Behavioural model state
  longint m_phase, m_freqA, m_ampA, m_freqS, m_ampS;
  bit     m_full;
  longint m_lut[2], m_x[2], m_s1[2], m_s2[2];
  bit     m_out[2];

  // Ideal full-wave sine sampled at bin centres of the ROM-addressing phase bits.
  function automatic longint ref_sine(input longint ph);
    longint k, m;
    real v;
    k = ph >> (PW - LUT_BITS - 2);
    v = $sin(2.0 * PI * (real'(k) + 0.5) / real'(longint'(1) << (LUT_BITS + 2)));
    m = longint'($floor(real'(AMAX) * (v < 0.0 ? -v : v) + 0.5));
    return (v < 0.0) ? -m : m;
  endfunction

  function automatic longint wrapm(input longint v);
    longint m;
    m = longint'(1) << MOD_W;
    v = v & (m - 1);
    if (v >= m / 2) v = v - m;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit cv, input longint f, input longint a);
    bit     old_full, copy;
    longint sum;
    if (r) begin
      m_phase = 0; m_freqA = 0; m_ampA = 0; m_freqS = 0; m_ampS = 0; m_full = 0;
      for (int c = 0; c < 2; c++) begin
        m_lut[c] = 0; m_x[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0;
      end
      return;
    end
    old_full = m_full;
    copy = 0;
    if (e) begin
      for (int c = 0; c < 2; c++) begin
        bit y;
        longint fb;
`ifdef SD_QUAD_MOD_ORDER2_EN
        y  = (m_s2[c] >= 0);
        fb = y ? FS : -FS;
        m_s2[c] = wrapm(m_s2[c] + m_s1[c] - fb);
        m_s1[c] = wrapm(m_s1[c] + m_x[c] - fb);
`else
        y  = (m_s1[c] >= 0);
        fb = y ? FS : -FS;
        m_s1[c] = wrapm(m_s1[c] + m_x[c] - fb);
`endif
        m_out[c] = y;
        m_x[c]   = (m_lut[c] * m_ampA) >>> WIDTH;
      end
      m_lut[0] = ref_sine(m_phase);
      m_lut[1] = ref_sine((m_phase + PMOD / 4) % PMOD);
      sum  = m_phase + m_freqA;
      copy = old_full && (sum >= PMOD || m_freqA == 0);
      m_phase = sum % PMOD;
    end
    if (!old_full && cv) begin
      m_freqS = f; m_ampS = a; m_full = 1;
    end else if (copy) begin
      m_freqA = m_freqS; m_ampA = m_ampS; m_full = 0;
    end
  endtask

  // Apply one clock of inputs, queue the outputs expected during this clock, advance the model.
  task automatic drive(input bit r, input bit e, input bit cv, input longint f, input longint a);
    bit wrap;
    rst          = r;
    bus.en       = e;
    bus.cfgValid = cv;
    bus.cfgFreq  = PW'(f);
    bus.cfgAmp   = WIDTH'(a);
    wrap = !r && e && (m_phase + m_freqA >= PMOD);
    if (chk_on) exp_q.push_back({!m_full, m_out[0], m_out[1], wrap});
    model_step(r, e, cv, f, a);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit e);
    repeat (n) drive(0, e, 0, 0, 0);
  endtask

  task automatic clear_counts();
    cnt_sin = 0; cnt_cos = 0; cnt_wrap = 0; last_iv = -1;
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    obs_t act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.cfgReady, bus.outSin, bus.outCos, bus.phaseWrap};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs t=%0t {rdy,sin,cos,wrap}: got %b, want %b", $time, act, exp);
      end
    end
    cnt_sin = cnt_sin + int'(bus.outSin === 1'b1);
    cnt_cos = cnt_cos + int'(bus.outCos === 1'b1);
    if (bus.en === 1'b1 && !rst) begin
      en_cnt++;
      if (bus.phaseWrap === 1'b1) begin
        cnt_wrap++;
        last_iv      = en_cnt - last_wrap_at;
        last_wrap_at = en_cnt;
      end
    end
  end

  initial begin
    en_cnt = 0; last_wrap_at = 0;
    clear_counts();
    bus.en = 0; bus.cfgValid = 0; bus.cfgFreq = '0; bus.cfgAmp = '0;
    drive(1, 0, 0, 0, 0);
    chk_on = 1;
    drive(1, 0, 0, 0, 0);

    // Idle tone: zero amplitude gives a 50% bitstream on both channels
    clear_counts();
    run(1024, 1);
    check_range("t1 sin ones", cnt_sin, 511, 513);
    check_range("t1 cos ones", cnt_cos, 511, 513);
    check_range("t1 wraps", cnt_wrap, 0, 0);

    // DC at phase 0, half amplitude
    drive(0, 1, 1, 0, 'h8000);
    run(6, 1);
    clear_counts();
    run(1024, 1);
    check_range("t2 cos ones", cnt_cos, 766, 770);
    check_range("t2 sin ones", cnt_sin, 510, 514);
    check_range("t2 wraps", cnt_wrap, 0, 0);

    // 16-sample tone at full amplitude
    drive(0, 1, 1, longint'(1) << (PW - 4), 'hFFFF);
    run(20, 1);
    clear_counts();
    run(64, 1);
    check_range("t3 wrap count", cnt_wrap, 4, 4);
    check_range("t3 wrap period", last_iv, 16, 16);

    // A accepted, B offered while shadow full and ignored
    drive(0, 1, 1, longint'(1) << (PW - 3), 'h4000);
    repeat (3) drive(0, 1, 1, longint'(1) << (PW - 5), 'h2000);
    run(60, 1);
    clear_counts();
    run(64, 1);
    check_range("t4 wrap count", cnt_wrap, 8, 8);
    check_range("t4 wrap period", last_iv, 8, 8);
    run(64, 1);
    check_range("t4 period after B", last_iv, 8, 8);

    // Enable gap mid-tone
    run(5, 1);
    run(100, 0);
    run(50, 1);

    // Reset with a pending shadow, then the idle-tone behaviour again
    drive(0, 1, 1, longint'(1) << (PW - 2), 'h1000);
    run(2, 1);
    drive(1, 1, 0, 0, 0);
    clear_counts();
    run(1024, 1);
    check_range("t6 sin ones", cnt_sin, 511, 513);
    check_range("t6 cos ones", cnt_cos, 511, 513);

    // Randomized enables, configs and occasional resets
    repeat (3000) begin
      bit     r, e, cv;
      longint f, a;
      r  = ($urandom_range(0, 499) == 0);
      e  = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(0, 1 << 21));
      a  = longint'($urandom_range(0, 65535));
      drive(r, e, cv, f, a);
    end
    run(4, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
